tc_spi_mux_master: RTL

TC_SPI_MUX_MASTER -- requirements
Module: tc_spi_mux_master

---
 rtl/tc_spi_mux_master.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tc_spi_mux_master.sv
// Multi-channel SPI master: one frame at a time on a selected channel,
// programmable mode, length and SCK divider per command.
module tc_spi_mux_master #(
    parameter int  NCH  = 5,
    parameter int  DW   = 32,
    parameter int  DIVW = 8,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW   = $clog2(DW + 1)
) (
    input  logic            clk125,
    input  logic            rst,
    input  logic            cmd_wr,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [LW-1:0]   cmd_len,
    input  logic [DW-1:0]   cmd_data,
    input  logic            cmd_cpol,
    input  logic            cmd_cpha,
    input  logic [DIVW-1:0] cmd_div,
    output logic            busy,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            cmd_err,
    output logic [NCH-1:0]  csn,
    output logic [NCH-1:0]  sck,
    output logic [NCH-1:0]  sdi,
    input  logic [NCH-1:0]  sdo
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ASSERT = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [DIVW-1:0] div_r, div_s, div_cnt_r, div_cnt_s;
    logic [LW:0]     hp_idx_r, hp_idx_s, hp_last_s, hp_next_s;
    logic [LW-1:0]   len_r, len_s;
    logic [CHW-1:0]  ch_r, ch_s;
    logic            cpol_r, cpol_s, cpha_r, cpha_s;
    logic [DW-1:0]   tx_r, tx_s, rx_r, rx_s;
    logic [DW-1:0]   tx_shift_s, rx_shift_s;
    logic [DW-1:0]   rd_data_r, rd_data_s;
    logic            sel_csn_r, sel_csn_s, sel_sck_r, sel_sck_s, sel_sdi_r, sel_sdi_s;
    logic            busy_r, busy_s, rd_valid_r, rd_valid_s, cmd_err_r, cmd_err_s;
    logic [NCH-1:0]  csn_r, csn_s, sck_r, sck_s, sdi_r, sdi_s;
    logic            tick_s, accept_s, sdo_sel_s;

    // Command qualification and datapath helpers
    always_comb begin
        tick_s     = (div_cnt_r == {DIVW{1'b0}});
        hp_last_s  = {len_r, 1'b0} - {{LW{1'b0}}, 1'b1};
        hp_next_s  = hp_idx_r + {{LW{1'b0}}, 1'b1};
        sdo_sel_s  = sdo[ch_r];
        tx_shift_s = {tx_r[DW-2:0], 1'b0};
        rx_shift_s = {rx_r[DW-2:0], sdo_sel_s};
        // The rd_valid cycle still counts as busy for acceptance purposes.
        accept_s   = cmd_wr && !busy_r && !rd_valid_r
                     && (cmd_len != {LW{1'b0}})
                     && (32'(cmd_len) <= 32'(DW))
                     && (32'(cmd_ch) < 32'(NCH));
    end

    // Next-state, datapath and output computation
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        div_cnt_s  = div_cnt_r;
        hp_idx_s   = hp_idx_r;
        len_s      = len_r;
        ch_s       = ch_r;
        cpol_s     = cpol_r;
        cpha_s     = cpha_r;
        tx_s       = tx_r;
        rx_s       = rx_r;
        sel_csn_s  = sel_csn_r;
        sel_sck_s  = sel_sck_r;
        sel_sdi_s  = sel_sdi_r;
        busy_s     = busy_r;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data_r;
        cmd_err_s  = cmd_wr & ~accept_s;
        csn_s      = {NCH{1'b1}};
        sck_s      = {NCH{1'b0}};
        sdi_s      = {NCH{1'b0}};

        if (state_r == ST_IDLE) begin
            div_cnt_s = div_cnt_r;
        end else if (tick_s) begin
            div_cnt_s = div_r;
        end else begin
            div_cnt_s = div_cnt_r - {{(DIVW-1){1'b0}}, 1'b1};
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s   = ST_LEAD;
                    div_s     = cmd_div;
                    div_cnt_s = cmd_div;
                    hp_idx_s  = {(LW+1){1'b0}};
                    len_s     = cmd_len;
                    ch_s      = cmd_ch;
                    cpol_s    = cmd_cpol;
                    cpha_s    = cmd_cpha;
                    // Left-align the frame so the next bit is always tx_r[DW-1].
                    tx_s      = cmd_data << (LW'(DW) - cmd_len);
                    rx_s      = {DW{1'b0}};
                    sel_csn_s = 1'b1;
                    sel_sck_s = cmd_cpol;
                    sel_sdi_s = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (tick_s) begin
                    state_s   = ST_ASSERT;
                    sel_csn_s = 1'b0;
                    sel_sdi_s = cpha_r ? 1'b0 : tx_r[DW-1];
                end else begin
                    state_s = ST_LEAD;
                end
            end
            ST_ASSERT: begin
                if (tick_s) begin
                    state_s   = ST_SHIFT;
                    hp_idx_s  = {(LW+1){1'b0}};
                    sel_sck_s = ~cpol_r;
                    if (cpha_r) begin
                        sel_sdi_s = tx_r[DW-1];
                    end else begin
                        rx_s = rx_shift_s;
                    end
                end else begin
                    state_s = ST_ASSERT;
                end
            end
            ST_SHIFT: begin
                if (!tick_s) begin
                    state_s = ST_SHIFT;
                end else if (hp_idx_r == hp_last_s) begin
                    state_s   = ST_HOLD;
                    sel_sck_s = cpol_r;
                end else begin
                    hp_idx_s  = hp_next_s;
                    sel_sck_s = ~sel_sck_r;
                    // Even half-periods start on a leading edge, odd ones on a trailing edge.
                    if (hp_next_s[0] == cpha_r) begin
                        rx_s = rx_shift_s;
                    end else if (hp_next_s != hp_last_s) begin
                        tx_s      = tx_shift_s;
                        sel_sdi_s = tx_r[DW-2];
                    end else begin
                        tx_s = tx_r;
                    end
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    state_s    = ST_IDLE;
                    sel_csn_s  = 1'b1;
                    sel_sck_s  = 1'b0;
                    sel_sdi_s  = 1'b0;
                    busy_s     = 1'b0;
                    rd_valid_s = 1'b1;
                    rd_data_s  = rx_r;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                sel_csn_s = 1'b1;
                sel_sck_s = 1'b0;
                sel_sdi_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase

        for (int i = 0; i < NCH; i++) begin
            if (int'(ch_s) == i) begin
                csn_s[i] = sel_csn_s;
                sck_s[i] = sel_sck_s;
                sdi_s[i] = sel_sdi_s;
            end else begin
                csn_s[i] = 1'b1;
                sck_s[i] = 1'b0;
                sdi_s[i] = 1'b0;
            end
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_r      <= {DIVW{1'b0}};
            div_cnt_r  <= {DIVW{1'b0}};
            hp_idx_r   <= {(LW+1){1'b0}};
            len_r      <= {LW{1'b0}};
            ch_r       <= {CHW{1'b0}};
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            tx_r       <= {DW{1'b0}};
            rx_r       <= {DW{1'b0}};
            sel_csn_r  <= 1'b1;
            sel_sck_r  <= 1'b0;
            sel_sdi_r  <= 1'b0;
            busy_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DW{1'b0}};
            cmd_err_r  <= 1'b0;
            csn_r      <= {NCH{1'b1}};
            sck_r      <= {NCH{1'b0}};
            sdi_r      <= {NCH{1'b0}};
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            div_cnt_r  <= div_cnt_s;
            hp_idx_r   <= hp_idx_s;
            len_r      <= len_s;
            ch_r       <= ch_s;
            cpol_r     <= cpol_s;
            cpha_r     <= cpha_s;
            tx_r       <= tx_s;
            rx_r       <= rx_s;
            sel_csn_r  <= sel_csn_s;
            sel_sck_r  <= sel_sck_s;
            sel_sdi_r  <= sel_sdi_s;
            busy_r     <= busy_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
            cmd_err_r  <= cmd_err_s;
            csn_r      <= csn_s;
            sck_r      <= sck_s;
            sdi_r      <= sdi_s;
        end
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign cmd_err  = cmd_err_r;
    assign csn      = csn_r;
    assign sck      = sck_r;
    assign sdi      = sdi_r;

endmodule
